// File: rtl/mux2_rr_arbiter.sv
// mux2_rr_arbiter
// Round-robin arbiter and sequencer in front of a 2:1 byte multiplexer.
// Two valid/ready producers share one registered output channel. A grant
// FSM drives the mux select and lets the granted source send a bounded
// burst before the other source gets its turn.
module mux2_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic             v0,
    output logic             r0,
    input  logic [WIDTH-1:0] d1,
    input  logic             v1,
    output logic             r1,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        G0,
        G1
    } state_t;

    state_t         state;
    logic           last;
    logic [CW-1:0]  beat_cnt;

    logic             load;
    logic             xfer;
    logic             cur_valid;
    logic             other_valid;
    logic             last_beat;
    logic             release_now;
    logic [WIDTH-1:0] mux_data;

    // Handshake decode: the output register can take a word when empty or draining
    always_comb begin
        load        = !out_valid || out_ready;
        r0          = (state == G0) && load;
        r1          = (state == G1) && load;
        xfer        = (r0 && v0) || (r1 && v1);
        mux_data    = sel ? d1 : d0;
        cur_valid   = (state == G1) ? v1 : v0;
        other_valid = (state == G1) ? v0 : v1;
        last_beat   = (beat_cnt == LAST_BEAT);
        release_now = !cur_valid || (xfer && last_beat);
        busy        = (state != IDLE) || out_valid;
    end

    // Grant FSM, burst counter and registered output channel
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 1'b0;
            last      <= 1'b1;
            beat_cnt  <= '0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (xfer) begin
                out       <= mux_data;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (v0 && v1) begin
                        state    <= last ? G0 : G1;
                        sel      <= !last;
                        last     <= !last;
                        beat_cnt <= '0;
                    end else if (v0) begin
                        state    <= G0;
                        sel      <= 1'b0;
                        last     <= 1'b0;
                        beat_cnt <= '0;
                    end else if (v1) begin
                        state    <= G1;
                        sel      <= 1'b1;
                        last     <= 1'b1;
                        beat_cnt <= '0;
                    end
                end
                G0, G1: begin
                    // A stalled channel freezes everything, including release
                    if (load) begin
                        if (release_now) begin
                            if (other_valid) begin
                                state    <= (state == G0) ? G1 : G0;
                                sel      <= (state == G0);
                                last     <= (state == G0);
                                beat_cnt <= '0;
                            end else if (cur_valid) begin
                                beat_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (xfer) begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb_mux2_rr_arbiter
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level reference model of the round-robin arbiter.
module tb_mux2_rr_arbiter;

    localparam int WIDTH     = 8;
    localparam int BURST_LEN = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] d0, d1;
    logic             v0, v1;
    logic             r0, r1;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             sel;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner of the channel (-1 when nobody), beats sent in
    // the current grant, which source is favoured on a tie, output register.
    int               m_owner;
    int               m_beats;
    int               m_prio;
    logic [WIDTH-1:0] m_out;
    logic             m_valid;
    logic             m_sel;

    logic [WIDTH-1:0] captured[$];
    bit               capture_on = 1'b0;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(
        .WIDTH    (WIDTH),
        .BURST_LEN(BURST_LEN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .d0       (d0),
        .v0       (v0),
        .r0       (r0),
        .d1       (d1),
        .v1       (v1),
        .r1       (r1),
        .out      (out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sel      (sel),
        .busy     (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_owner = -1;
        m_beats = 0;
        m_prio  = 0;
        m_out   = '0;
        m_valid = 1'b0;
        m_sel   = 1'b0;
    endtask

    task automatic modelGrant(input int k);
        m_owner = k;
        m_beats = 0;
        m_sel   = (k == 1);
        m_prio  = 1 - k;
    endtask

    // One cycle: drive inputs, check outputs against the model, advance the model
    task automatic applyStimulus(input logic rst_i, input logic v0_i, input logic [WIDTH-1:0] d0_i,
                                 input logic v1_i, input logic [WIDTH-1:0] d1_i,
                                 input logic ordy_i);
        bit               vin[2];
        logic [WIDTH-1:0] din[2];
        bit               can_load, accept, done;
        int               other;

        @(negedge clk);
        rst       = rst_i;
        v0        = v0_i;
        d0        = d0_i;
        v1        = v1_i;
        d1        = d1_i;
        out_ready = ordy_i;
        #1;

        can_load = !m_valid || ordy_i;
        checkOutput("out",       out,       m_out);
        checkOutput("out_valid", out_valid, m_valid);
        checkOutput("sel",       sel,       m_sel);
        checkOutput("r0",        r0,        (m_owner == 0) && can_load);
        checkOutput("r1",        r1,        (m_owner == 1) && can_load);
        checkOutput("busy",      busy,      (m_owner >= 0) || m_valid);

        if (capture_on && out_valid === 1'b1) captured.push_back(out);

        if (rst_i) begin
            modelReset();
        end else begin
            vin[0] = v0_i;
            vin[1] = v1_i;
            din[0] = d0_i;
            din[1] = d1_i;
            accept = (m_owner >= 0) && can_load && vin[m_owner];
            if (accept) begin
                m_out   = din[m_owner];
                m_valid = 1'b1;
            end else if (ordy_i) begin
                m_valid = 1'b0;
            end

            if (m_owner < 0) begin
                if (vin[0] && vin[1]) modelGrant(m_prio);
                else if (vin[0])      modelGrant(0);
                else if (vin[1])      modelGrant(1);
            end else if (can_load) begin
                done = !vin[m_owner] || (accept && (m_beats + 1 == BURST_LEN));
                if (accept) m_beats++;
                if (done) begin
                    other = 1 - m_owner;
                    if (vin[other])          modelGrant(other);
                    else if (vin[m_owner])   m_beats = 0;
                    else                     m_owner = -1;
                end
            end
        end
    endtask

    initial begin
        logic [WIDTH-1:0] expw;

        rst       = 1'b1;
        v0        = 1'b0;
        v1        = 1'b0;
        d0        = '0;
        d1        = '0;
        out_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out",       out,       0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_sel",       sel,       0);
        checkOutput("rst_r0",        r0,        0);
        checkOutput("rst_r1",        r1,        0);
        checkOutput("rst_busy",      busy,      0);

        $display("[TB] single source 0 streaming");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (12) applyStimulus(1'b0, 1'b1, 8'h01, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h01, 1'b0, 8'h00, 1'b1);

        $display("[TB] both sources alternating bursts");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        capture_on = 1'b1;
        repeat (16) applyStimulus(1'b0, 1'b1, 8'h71, 1'b1, 8'h06, 1'b1);
        capture_on = 1'b0;
        checkOutput("burst_count", captured.size() >= 12, 1);
        for (int i = 0; i < 12 && i < captured.size(); i++) begin
            expw = (i >= 4 && i < 8) ? 8'h06 : 8'h71;
            checkOutput("burst_order", captured[i], expw);
        end

        $display("[TB] backpressure inside a source 1 burst");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1);

        $display("[TB] early release from source 1 to source 0");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h21, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h33, 1'b0, 8'h21, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h34, 1'b0, 8'h21, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0, 8'h34, 1'b0, 8'h21, 1'b1);

        $display("[TB] reset in the middle of a burst");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 8'h5a, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 149) == 0,
                          $urandom_range(0, 3) != 0, 8'($urandom),
                          $urandom_range(0, 3) != 0, 8'($urandom),
                          $urandom_range(0, 3) != 0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
